// File: rtl/result_framer_pkg.sv
// Shared definitions for the result framer: frame geometry, default start-of-frame
// byte, counter width and the framer state encoding.
package result_framer_pkg;

  localparam logic [7:0] SOF_DEFAULT   = 8'hA5;
  localparam int         FRAME_LEN     = 10;
  localparam int         IDX_W         = 4;
  localparam int         CNT_W_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/result_framer_cycle_counter.sv
// Job cycle counter for the result framer.
// Counts edges since the last job start, saturating at all-ones, and offers the
// value a result arriving on this edge should report.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low
//   enable   in   count enable while a job is running
//   clear    in   job start: count restarts from 0 and the job is marked running
//   capture  in   result seen: the job stops running
//   cap_val  out  saturated count+1 while running, 0 when no job is running
module cycle_counter
  import result_framer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             capture,
  output logic [CNT_W-1:0] cap_val
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             running;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // The capture edge itself is counted, so a result on the edge after job
  // start reports 1.
  assign cap_val = running ? sat_inc(cnt) : '0;

  // Job start outranks capture: on a shared edge the old count has already been
  // offered on cap_val, and the new job starts counting from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b1;
    end else if (capture) begin
      running <= 1'b0;
    end else if (running && enable) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/result_framer.sv
// Result framer: turns each finished mining job into a 10-byte frame on a
// valid/ready byte stream.
// Frame: SOF, nonce[31:0] MSB first, job cycle count MSB first, XOR of bytes 1-8.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low; clears all state
//   job_start   in   one-cycle pulse when a new job is released
//   finished    in   level, high once the nonce is found
//   nonce_in    in   winning nonce, valid while finished=1
//   tx_ready    in   sink accepts tx_data on an edge with tx_valid=1
//   tx_valid    out  tx_data carries a frame byte
//   tx_data     out  frame byte (0 when idle)
//   busy        out  a captured frame is not yet fully sent
//   frame_done  out  one-cycle pulse after the last byte is accepted
//   overrun     out  sticky: a result arrived while busy and was dropped
module result_framer
  import result_framer_pkg::*;
#(
  parameter logic [7:0] SOF   = SOF_DEFAULT,
  parameter int         CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_start,
  input  logic        finished,
  input  logic [31:0] nonce_in,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state_q, state_d;
  logic             fin_q;
  logic             rise;
  logic             accept;
  logic             last_accept;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      cap_nonce_q;
  logic [CNT_W-1:0] cap_cnt_q;
  logic [CNT_W-1:0] cnt_cap_val;
  logic [7:0]       checksum;

  // A result is the rising edge of the finished level; fin_q clears on reset so
  // a level already high at reset release still produces one frame.
  assign rise = finished & ~fin_q;

  cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .enable  (1'b1),
    .clear   (job_start),
    .capture (rise),
    .cap_val (cnt_cap_val)
  );

  assign tx_valid    = (state_q == SEND);
  assign busy        = (state_q == SEND);
  assign accept      = tx_valid & tx_ready;
  assign last_accept = accept & (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = SEND;
      SEND:    if (last_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture stage: nonce and count are frozen here; later input changes cannot
  // reach the frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fin_q       <= 1'b0;
      idx_q       <= '0;
      cap_nonce_q <= '0;
      cap_cnt_q   <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      fin_q      <= finished;
      frame_done <= last_accept;
      // Still SEND on the edge the last byte goes out, so a result there is lost too.
      if (rise && state_q == SEND) overrun <= 1'b1;
      if (rise && state_q == IDLE) begin
        cap_nonce_q <= nonce_in;
        cap_cnt_q   <= cnt_cap_val;
        idx_q       <= '0;
      end else if (accept) begin
        idx_q <= idx_q + IDX_ONE;
      end
    end
  end

  // Byte stage: SOF is left out of the checksum.
  assign checksum = cap_nonce_q[31:24] ^ cap_nonce_q[23:16] ^ cap_nonce_q[15:8] ^ cap_nonce_q[7:0]
                  ^ cap_cnt_q[31:24]   ^ cap_cnt_q[23:16]   ^ cap_cnt_q[15:8]   ^ cap_cnt_q[7:0];

  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:    tx_data = SOF;
        4'd1:    tx_data = cap_nonce_q[31:24];
        4'd2:    tx_data = cap_nonce_q[23:16];
        4'd3:    tx_data = cap_nonce_q[15:8];
        4'd4:    tx_data = cap_nonce_q[7:0];
        4'd5:    tx_data = cap_cnt_q[31:24];
        4'd6:    tx_data = cap_cnt_q[23:16];
        4'd7:    tx_data = cap_cnt_q[15:8];
        4'd8:    tx_data = cap_cnt_q[7:0];
        4'd9:    tx_data = checksum;
        default: tx_data = 8'h00;
      endcase
    end
  end

endmodule
